// File: rtl/sync_timing_detect_if.sv
// Sync timing detector bus: incoming hsync/vsync from the sync source plus the
// recovered position counters, stored timing measurements and status pulses.
//   master : drives hsync/vsync, observes all results
//   slave  : the detector; samples hsync/vsync, drives all results
interface sync_timing_detect_if;
    localparam int unsigned CW = 16;

    logic          hsync;
    logic          vsync;
    logic [CW-1:0] hpos;
    logic [CW-1:0] vpos;
    logic [CW-1:0] h_total;
    logic [CW-1:0] h_sync_w;
    logic [CW-1:0] v_total;
    logic [CW-1:0] v_sync_w;
    logic          locked;
    logic          frame_start;
    logic          sync_err;

    modport master (
        output hsync, vsync,
        input  hpos, vpos, h_total, h_sync_w, v_total, v_sync_w,
        input  locked, frame_start, sync_err
    );

    modport slave (
        input  hsync, vsync,
        output hpos, vpos, h_total, h_sync_w, v_total, v_sync_w,
        output locked, frame_start, sync_err
    );
endinterface

// File: rtl/sync_timing_detect.sv
// Receive-side sync timing detector. Measures line period, hsync width, lines
// per frame and vsync width from active-high hsync/vsync, recovers hpos/vpos
// relative to the sync leading edges and declares lock after LOCK_FRAMES
// consecutive identical frames.
// Ports:
//   clk   pixel clock
//   nrst  asynchronous active-low reset
//   bus   slave side of sync_timing_detect_if
//         in : hsync, vsync
//         out: hpos, vpos, h_total, h_sync_w, v_total, v_sync_w (16 bit),
//              locked, frame_start (pulse), sync_err (pulse)
module sync_timing_detect #(
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned MAX_HTOTAL  = 4095,
    parameter int unsigned MAX_VTOTAL  = 2047
) (
    input logic                 clk,
    input logic                 nrst,
    sync_timing_detect_if.slave bus
);

    localparam int unsigned CW = 16;
    localparam int unsigned MW = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          hsync_d, vsync_d;
    logic          hrise, hfall, vrise, vfall;
    logic [CW-1:0] hpos, vpos, hwidth, vwidth;
    logic [CW-1:0] h_total, h_sync_w, v_total, v_sync_w;
    logic [CW-1:0] h_total_nxt, h_sync_w_nxt, v_total_nxt, v_sync_w_nxt;
    logic [CW-1:0] line_len, frame_len;
    logic [MW-1:0] match_cnt, match_cnt_nxt;
    logic [MW:0]   cnt_inc;
    logic          frame_bad, frame_bad_nxt;
    logic          mismatch, timeout;
    logic          locked, frame_start, sync_err, sync_err_nxt;

    // Edge detection against the previous-cycle sync levels
    assign hrise = bus.hsync & ~hsync_d;
    assign hfall = ~bus.hsync & hsync_d;
    assign vrise = bus.vsync & ~vsync_d;
    assign vfall = ~bus.vsync & vsync_d;

    // The edge cycle itself closes the line/frame being measured
    assign line_len  = hpos + CW'(1);
    assign frame_len = vpos + CW'(1);
    assign timeout   = (hpos == CW'(MAX_HTOTAL)) || (vpos == CW'(MAX_VTOTAL));

    // Free-running position and width counters, all saturating
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hsync_d <= 1'b0;
            vsync_d <= 1'b0;
            hpos    <= '0;
            vpos    <= '0;
            hwidth  <= '0;
            vwidth  <= '0;
        end else begin
            hsync_d <= bus.hsync;
            vsync_d <= bus.vsync;

            if (hrise) begin
                hpos <= '0;
            end else if (hpos != CW'(MAX_HTOTAL)) begin
                hpos <= hpos + CW'(1);
            end

            if (hrise) begin
                hwidth <= CW'(1);
            end else if (bus.hsync && (hwidth != '1)) begin
                hwidth <= hwidth + CW'(1);
            end

            // vrise wins over a coincident hrise: that line belongs to the old frame
            if (vrise) begin
                vpos <= '0;
            end else if (hrise && (vpos != CW'(MAX_VTOTAL))) begin
                vpos <= vpos + CW'(1);
            end

            if (vrise) begin
                vwidth <= '0;
            end else if (hrise && bus.vsync && (vwidth != '1)) begin
                vwidth <= vwidth + CW'(1);
            end
        end
    end

    // Lock FSM state and registered measurement/status outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= SEARCH;
            match_cnt   <= '0;
            frame_bad   <= 1'b0;
            h_total     <= '0;
            h_sync_w    <= '0;
            v_total     <= '0;
            v_sync_w    <= '0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            match_cnt   <= match_cnt_nxt;
            frame_bad   <= frame_bad_nxt;
            h_total     <= h_total_nxt;
            h_sync_w    <= h_sync_w_nxt;
            v_total     <= v_total_nxt;
            v_sync_w    <= v_sync_w_nxt;
            locked      <= (state_nxt == LOCKED);
            frame_start <= vrise;
            sync_err    <= sync_err_nxt;
        end
    end

    // Next-state: load/compare measurements at each sync edge
    always_comb begin
        state_nxt     = state;
        match_cnt_nxt = match_cnt;
        frame_bad_nxt = frame_bad;
        h_total_nxt   = h_total;
        h_sync_w_nxt  = h_sync_w;
        v_total_nxt   = v_total;
        v_sync_w_nxt  = v_sync_w;
        sync_err_nxt  = 1'b0;
        mismatch      = 1'b0;
        cnt_inc       = {1'b0, match_cnt} + (MW+1)'(1);

        case (state)
            SEARCH: begin
                if (vrise) begin
                    state_nxt     = VERIFY;
                    match_cnt_nxt = '0;
                    frame_bad_nxt = 1'b0;
                    h_total_nxt   = '0;
                    h_sync_w_nxt  = '0;
                    v_total_nxt   = '0;
                    v_sync_w_nxt  = '0;
                end
            end

            VERIFY: begin
                if (timeout) begin
                    state_nxt = SEARCH;
                end else begin
                    // A zero stored value is an empty slot: load without complaint
                    if (hrise) begin
                        mismatch    = mismatch | ((h_total != '0) && (h_total != line_len));
                        h_total_nxt = line_len;
                    end
                    if (hfall) begin
                        mismatch     = mismatch | ((h_sync_w != '0) && (h_sync_w != hwidth));
                        h_sync_w_nxt = hwidth;
                    end
                    if (vrise) begin
                        mismatch    = mismatch | ((v_total != '0) && (v_total != frame_len));
                        v_total_nxt = frame_len;
                    end
                    if (vfall) begin
                        mismatch     = mismatch | ((v_sync_w != '0) && (v_sync_w != vwidth));
                        v_sync_w_nxt = vwidth;
                    end

                    if (mismatch) begin
                        match_cnt_nxt = '0;
                        frame_bad_nxt = 1'b1;
                    end

                    // Frame boundary: credit the completed frame if it stayed clean
                    if (vrise) begin
                        frame_bad_nxt = 1'b0;
                        if (!mismatch && !frame_bad) begin
                            match_cnt_nxt = cnt_inc[MW-1:0];
                            if (cnt_inc >= (MW+1)'(LOCK_FRAMES)) begin
                                state_nxt = LOCKED;
                            end
                        end
                    end
                end
            end

            LOCKED: begin
                mismatch = (hrise && (line_len != h_total))  ||
                           (hfall && (hwidth   != h_sync_w)) ||
                           (vrise && (frame_len != v_total)) ||
                           (vfall && (vwidth   != v_sync_w));
                if (mismatch || timeout) begin
                    state_nxt    = SEARCH;
                    sync_err_nxt = 1'b1;
                end
            end

            default: state_nxt = SEARCH;
        endcase
    end

    assign bus.hpos        = hpos;
    assign bus.vpos        = vpos;
    assign bus.h_total     = h_total;
    assign bus.h_sync_w    = h_sync_w;
    assign bus.v_total     = v_total;
    assign bus.v_sync_w    = v_sync_w;
    assign bus.locked      = locked;
    assign bus.frame_start = frame_start;
    assign bus.sync_err    = sync_err;

endmodule

// File: tb/tb_sync_timing_detect.sv
// Bench for sync_timing_detect: directed timing scenarios plus randomized
// timing perturbations, checked every cycle against a timestamp-based model.
module tb_sync_timing_detect;

    localparam int unsigned LOCKF = 2;
    localparam int unsigned MAXH  = 4095;
    localparam int unsigned MAXV  = 2047;
    localparam int          BIG   = 1 << 30;

    localparam int M_SEARCH = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    sync_timing_detect_if bus ();

    sync_timing_detect #(
        .LOCK_FRAMES (LOCKF),
        .MAX_HTOTAL  (MAXH),
        .MAX_VTOTAL  (MAXV)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int checks   = 0;
    int errors   = 0;
    int err_seen = 0;
    bit chk_en   = 1'b0;

    // Reference model state: timestamps and event counts
    longint m_n, m_last_hr;
    int     m_hr_since_v;
    bit     m_hd, m_vd;
    int     m_mode, m_cnt;
    bit     m_bad;
    int     st_h, st_hw, st_v, st_vw;
    int     exp_hpos, exp_vpos;
    bit     exp_locked, exp_fs, exp_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int imin(input longint a, input longint b);
        return (a < b) ? int'(a) : int'(b);
    endfunction

    task automatic model_reset();
        m_n = 0; m_last_hr = -1; m_hr_since_v = 0;
        m_hd = 0; m_vd = 0; m_mode = M_SEARCH; m_cnt = 0; m_bad = 0;
        st_h = 0; st_hw = 0; st_v = 0; st_vw = 0;
        exp_hpos = 0; exp_vpos = 0; exp_locked = 0; exp_fs = 0; exp_err = 0;
    endtask

    task automatic model_step(input bit h, input bit v);
        bit hr, hf, vr, vf, tmo, mm;
        int line_len, hw_len, frame_len, vw_len;
        hr = h && !m_hd;  hf = !h && m_hd;
        vr = v && !m_vd;  vf = !v && m_vd;
        tmo       = (exp_hpos == int'(MAXH)) || (exp_vpos == int'(MAXV));
        line_len  = exp_hpos + 1;
        hw_len    = int'(m_n - m_last_hr);
        frame_len = exp_vpos + 1;
        vw_len    = m_hr_since_v;
        exp_err   = 0;
        mm        = 0;
        if (m_mode == M_SEARCH) begin
            if (vr) begin
                m_mode = M_VERIFY; m_cnt = 0; m_bad = 0;
                st_h = 0; st_hw = 0; st_v = 0; st_vw = 0;
            end
        end else if (m_mode == M_VERIFY) begin
            if (tmo) m_mode = M_SEARCH;
            else begin
                if (hr) begin if (st_h  != 0 && st_h  != line_len)  mm = 1; st_h  = line_len;  end
                if (hf) begin if (st_hw != 0 && st_hw != hw_len)    mm = 1; st_hw = hw_len;    end
                if (vr) begin if (st_v  != 0 && st_v  != frame_len) mm = 1; st_v  = frame_len; end
                if (vf) begin if (st_vw != 0 && st_vw != vw_len)    mm = 1; st_vw = vw_len;    end
                if (mm) begin m_cnt = 0; m_bad = 1; end
                if (vr) begin
                    if (!m_bad) m_cnt++;
                    m_bad = 0;
                    if (m_cnt >= int'(LOCKF)) m_mode = M_LOCKED;
                end
            end
        end else begin
            mm = (hr && line_len != st_h) || (hf && hw_len != st_hw) ||
                 (vr && frame_len != st_v) || (vf && vw_len != st_vw);
            if (mm || tmo) begin exp_err = 1; m_mode = M_SEARCH; end
        end
        if (hr) m_last_hr = m_n;
        if (vr) m_hr_since_v = 0;
        else if (hr) m_hr_since_v++;
        exp_hpos   = hr ? 0 : imin(m_n - m_last_hr, longint'(MAXH));
        exp_vpos   = vr ? 0 : imin(longint'(m_hr_since_v), longint'(MAXV));
        exp_locked = (m_mode == M_LOCKED);
        exp_fs     = vr;
        m_hd = h; m_vd = v;
        m_n++;
    endtask

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("hpos",        32'(bus.hpos),        32'(exp_hpos));
            chk("vpos",        32'(bus.vpos),        32'(exp_vpos));
            chk("h_total",     32'(bus.h_total),     32'(st_h));
            chk("h_sync_w",    32'(bus.h_sync_w),    32'(st_hw));
            chk("v_total",     32'(bus.v_total),     32'(st_v));
            chk("v_sync_w",    32'(bus.v_sync_w),    32'(st_vw));
            chk("locked",      32'(bus.locked),      32'(exp_locked));
            chk("frame_start", 32'(bus.frame_start), 32'(exp_fs));
            chk("sync_err",    32'(bus.sync_err),    32'(exp_err));
            if (bus.sync_err === 1'b1) err_seen++;
        end
    end

    task automatic tick(input bit h, input bit v);
        bus.hsync = h;
        bus.vsync = v;
        @(posedge clk);
        model_step(h, v);
        #1;
    endtask

    // vsync rises with the hsync of line 0 and falls at the hsync fall of line vsw
    task automatic frame_part(input int htot, input int hsw, input int vtot, input int vsw,
                              input int long_l, input int from, input int upto);
        int k = 0;
        for (int l = 0; l < vtot; l++) begin
            int len = htot + ((l == long_l) ? 1 : 0);
            for (int c = 0; c < len; c++) begin
                if (k >= from && k < upto)
                    tick(c < hsw, (l < vsw) || (l == vsw && c < hsw));
                k++;
            end
        end
    endtask

    task automatic send_frame(input int htot, input int hsw, input int vtot, input int vsw,
                              input int long_l);
        frame_part(htot, hsw, vtot, vsw, long_l, 0, BIG);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int e0;
        int h, hs, vt, vs, r;
        bus.hsync = 1'b0;
        bus.vsync = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hpos",    32'(bus.hpos),    0);
        chk("rst_h_total", 32'(bus.h_total), 0);
        chk("rst_v_total", 32'(bus.v_total), 0);
        chk("rst_locked",  32'(bus.locked),  0);
        #2;
        nrst = 1'b1;
        model_reset();
        chk_en = 1'b1;

        // Nominal timing: lock on the 3rd vrise, coincident vrise/hrise
        repeat (7) tick(0, 0);
        send_frame(32, 4, 10, 2, -1);
        send_frame(32, 4, 10, 2, -1);
        chk("lock_before_3rd_vrise", 32'(bus.locked), 0);
        frame_part(32, 4, 10, 2, -1, 0, 1);
        chk("lock_at_3rd_vrise",   32'(bus.locked),      1);
        chk("frame_start_pulse",   32'(bus.frame_start), 1);
        chk("vpos_after_coincide", 32'(bus.vpos),        0);
        chk("lit_h_total",         32'(bus.h_total),     32);
        chk("lit_h_sync_w",        32'(bus.h_sync_w),    4);
        chk("lit_v_total",         32'(bus.v_total),     10);
        chk("lit_v_sync_w",        32'(bus.v_sync_w),    2);
        frame_part(32, 4, 10, 2, -1, 1, BIG);
        send_frame(32, 4, 10, 2, -1);

        // Missing hsync while locked
        e0 = err_seen;
        repeat (4100) tick(0, 0);
        chk("timeout_err_pulses", 32'(err_seen - e0), 1);
        chk("timeout_hpos_sat",   32'(bus.hpos),      4095);
        chk("timeout_unlocked",   32'(bus.locked),    0);

        // Asynchronous reset mid-line, then relock from a partial frame
        send_frame(32, 4, 10, 2, -1);
        frame_part(32, 4, 10, 2, -1, 0, 40);
        #2;
        nrst   = 1'b0;
        chk_en = 1'b0;
        #1;
        chk("arst_hpos",    32'(bus.hpos),    0);
        chk("arst_h_total", 32'(bus.h_total), 0);
        chk("arst_v_total", 32'(bus.v_total), 0);
        chk("arst_locked",  32'(bus.locked),  0);
        bus.hsync = 1'b0;
        bus.vsync = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        nrst = 1'b1;
        model_reset();
        chk_en = 1'b1;
        frame_part(32, 4, 10, 2, -1, 150, BIG);
        send_frame(32, 4, 10, 2, -1);
        send_frame(32, 4, 10, 2, -1);
        chk("relock_not_yet", 32'(bus.locked), 0);
        frame_part(32, 4, 10, 2, -1, 0, 1);
        chk("relock_after_rst", 32'(bus.locked), 1);
        frame_part(32, 4, 10, 2, -1, 1, BIG);

        // One 33-clock line while locked, then vsync width change during verify
        e0 = err_seen;
        send_frame(32, 4, 10, 2, 5);
        chk("long_line_err",      32'(err_seen - e0), 1);
        chk("long_line_unlocked", 32'(bus.locked),    0);
        e0 = err_seen;
        send_frame(32, 4, 10, 2, -1);
        send_frame(32, 4, 10, 3, -1);
        send_frame(32, 4, 10, 3, -1);
        send_frame(32, 4, 10, 3, -1);
        chk("vsw_change_unlocked", 32'(bus.locked), 0);
        frame_part(32, 4, 10, 3, -1, 0, 1);
        chk("vsw_change_locked", 32'(bus.locked),   1);
        chk("vsw_new_width",     32'(bus.v_sync_w), 3);
        chk("vsw_no_err",        32'(err_seen - e0), 0);
        frame_part(32, 4, 10, 3, -1, 1, BIG);

        // Randomized timing perturbations and noise
        h = 32; hs = 4; vt = 10; vs = 3;
        for (int f = 0; f < 40; f++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0: h  = int'($urandom_range(24, 40));
                1: hs = int'($urandom_range(2, 6));
                2: vt = int'($urandom_range(8, 14));
                3: vs = int'($urandom_range(1, 3));
                5: repeat (int'($urandom_range(1, 20))) tick(1'($urandom), 1'($urandom));
                default: ;
            endcase
            send_frame(h, hs, vt, vs, (r == 4) ? int'($urandom_range(0, vt - 1)) : -1);
        end
        repeat (3) tick(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
